// File: rtl/hippo_lsu_pkg.sv
// Shared types and helpers for the Hippomenes load/store unit.
// Optional build macro HIPPO_LSU_MISALIGN_TRAP_EN is consumed by hippo_lsu_ctrl.
package hippo_lsu_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT_R,
      DONE
   } LsuState;

   typedef enum logic [1:0] {
      NONE,
      LOAD_MISALIGN,
      STORE_MISALIGN,
      BUS_TIMEOUT
   } TrapCause;

   // Access size as carried in funct3[1:0].
   localparam logic [1:0] MEM_B = 2'd0;
   localparam logic [1:0] MEM_H = 2'd1;
   localparam logic [1:0] MEM_W = 2'd2;

   // funct3[1:0] == 3 has no RV32 meaning; it is folded onto a word access.
   function automatic logic [1:0] decode_width(input logic [2:0] width);
      return (width[1:0] == 2'd3) ? MEM_W : width[1:0];
   endfunction

   // True when the access does not sit on its natural boundary.
   function automatic logic is_misaligned(input logic [2:0] width,
                                          input logic [1:0] addr_lo);
      logic [1:0] size;
      size = decode_width(width);
      return ((size == MEM_H) && addr_lo[0]) ||
             ((size == MEM_W) && (addr_lo != 2'b00));
   endfunction

endpackage

// File: rtl/hippo_lsu_ctrl_if.sv
// Data-memory request/grant/rvalid bus between the LSU and the memory port.
// master = LSU side, slave = memory side.
interface hippo_lsu_ctrl_if #(
   parameter int XLEN = 32
);

   logic            o_bus_req;
   logic            o_bus_we;
   logic [XLEN-1:0] o_bus_addr;
   logic [3:0]      o_bus_be;
   logic [XLEN-1:0] o_bus_wdata;
   logic            i_bus_gnt;
   logic            i_bus_rvalid;
   logic [XLEN-1:0] i_bus_rdata;

   modport master (
      output o_bus_req, o_bus_we, o_bus_addr, o_bus_be, o_bus_wdata,
      input  i_bus_gnt, i_bus_rvalid, i_bus_rdata
   );

   modport slave (
      input  o_bus_req, o_bus_we, o_bus_addr, o_bus_be, o_bus_wdata,
      output i_bus_gnt, i_bus_rvalid, i_bus_rdata
   );

endinterface

// File: rtl/hippo_lsu_lane.sv
// Byte-lane steering for the LSU: byte enables, store-data replication and
// load lane extraction with sign/zero extension. Purely combinational.
// Half accesses look only at addr[1] and word accesses ignore addr[1:0], so
// the same steering serves builds with or without misalignment trapping.
module hippo_lsu_lane
   import hippo_lsu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [1:0]      addr_lo,
   input  logic [2:0]      width,
   input  logic [XLEN-1:0] wdata,
   input  logic [XLEN-1:0] rdata_raw,
   output logic [3:0]      be,
   output logic [XLEN-1:0] wdata_rep,
   output logic [XLEN-1:0] rdata_ext
);

   logic [1:0]  size;
   logic        sign_en;
   logic [7:0]  lane_byte;
   logic [15:0] lane_half;

   assign size      = decode_width(width);
   assign sign_en   = ~width[2];
   assign lane_byte = rdata_raw[{addr_lo, 3'b000} +: 8];
   assign lane_half = rdata_raw[{addr_lo[1], 4'b0000} +: 16];

   // Steer enables, store data and load data by access size.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      be        = 4'b1111;
      wdata_rep = wdata;
      rdata_ext = rdata_raw;
      case (size)
         MEM_B: begin
            be        = 4'b0001 << addr_lo;
            wdata_rep = {4{wdata[7:0]}};
            rdata_ext = {{24{sign_en & lane_byte[7]}}, lane_byte};
         end
         MEM_H: begin
            be        = 4'b0011 << {addr_lo[1], 1'b0};
            wdata_rep = {2{wdata[15:0]}};
            rdata_ext = {{16{sign_en & lane_half[15]}}, lane_half};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/hippo_lsu_ctrl.sv
// Load/store sequencer for the Hippomenes execute stage. Runs the data-memory
// request/grant/rvalid handshake, stalls the pipeline until completion and
// reports misalignment (optional) and bus-timeout traps.
// Build macro: HIPPO_LSU_MISALIGN_TRAP_EN enables misaligned-access traps.
module hippo_lsu_ctrl
   import hippo_lsu_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_valid,
   input  logic              i_load,
   input  logic              i_store,
   input  logic [2:0]        i_width,
   input  logic [XLEN-1:0]   i_addr,
   input  logic [XLEN-1:0]   i_wdata,
   output logic              o_stall,
   output logic [XLEN-1:0]   o_rdata,
   output logic              o_rdata_valid,
   output logic              o_trap,
   output logic [1:0]        o_trap_cause,
   hippo_lsu_ctrl_if.master  bus
);

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   LsuState         state_q, state_d;
   logic [XLEN-1:0] addr_q, wdata_q, rdata_q;
   logic [2:0]      width_q;
   logic            store_q;
   logic            timeout_q;
   logic [7:0]      cnt_q;

   logic            mem_op, misaligned;
   logic            capture_op, capture_rdata, timeout_fire;
   logic [3:0]      lane_be;
   logic [XLEN-1:0] lane_wdata, lane_rdata;

   // Qualified by reset so a held instruction cannot raise o_stall while in reset.
   assign mem_op = i_reset & i_valid & (i_load | i_store);

`ifdef HIPPO_LSU_MISALIGN_TRAP_EN
   assign misaligned = is_misaligned(i_width, i_addr[1:0]);
`else
   assign misaligned = 1'b0;
`endif

   hippo_lsu_lane #(.XLEN(XLEN)) u_lane (
      .addr_lo   (addr_q[1:0]),
      .width     (width_q),
      .wdata     (wdata_q),
      .rdata_raw (bus.i_bus_rdata),
      .be        (lane_be),
      .wdata_rep (lane_wdata),
      .rdata_ext (lane_rdata)
   );

   // Bus outputs come from the capture registers so they hold steady until grant.
   assign bus.o_bus_addr  = {addr_q[XLEN-1:2], 2'b00};
   assign bus.o_bus_we    = store_q & (state_q == REQ);
   assign bus.o_bus_be    = (state_q == REQ) ? lane_be : 4'b0000;
   assign bus.o_bus_wdata = lane_wdata;
   assign o_rdata         = rdata_q;

   // State register.
   always_ff @(posedge i_clk or negedge i_reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!i_reset) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next-state and output decode.
   always_comb begin
      state_d       = state_q;
      o_stall       = 1'b0;
      o_trap        = 1'b0;
      o_trap_cause  = NONE;
      o_rdata_valid = 1'b0;
      bus.o_bus_req = 1'b0;
      capture_op    = 1'b0;
      capture_rdata = 1'b0;
      timeout_fire  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (mem_op) begin
               if (misaligned) begin
                  o_trap       = 1'b1;
                  o_trap_cause = i_store ? STORE_MISALIGN : LOAD_MISALIGN;
               end else begin
                  o_stall    = 1'b1;
                  capture_op = 1'b1;
                  state_d    = REQ;
               end
            end
         end
         REQ: begin
            o_stall       = 1'b1;
            bus.o_bus_req = 1'b1;
            if (bus.i_bus_gnt) begin
               if (store_q) begin
                  state_d = DONE;
               end else if (bus.i_bus_rvalid) begin
                  capture_rdata = 1'b1;
                  state_d       = DONE;
               end else begin
                  state_d = WAIT_R;
               end
            end else if (cnt_q >= CNT_LAST) begin
               timeout_fire = 1'b1;
               state_d      = DONE;
            end
         end
         WAIT_R: begin
            o_stall = 1'b1;
            if (bus.i_bus_rvalid) begin
               capture_rdata = 1'b1;
               state_d       = DONE;
            end else if (cnt_q >= CNT_LAST) begin
               timeout_fire = 1'b1;
               state_d      = DONE;
            end
         end
         DONE: begin
            o_trap        = timeout_q;
            o_trap_cause  = timeout_q ? BUS_TIMEOUT : NONE;
            o_rdata_valid = ~timeout_q & ~store_q;
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Capture the accepted operation; also clears the pending timeout.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         addr_q    <= '0;
         width_q   <= '0;
         wdata_q   <= '0;
         store_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else if (capture_op) begin
         addr_q    <= i_addr;
         width_q   <= i_width;
         wdata_q   <= i_wdata;
         store_q   <= i_store;
         timeout_q <= 1'b0;
      end else if (timeout_fire) begin
         timeout_q <= 1'b1;
      end
   end

   // Cycles spent waiting on the bus; cleared when a new access is accepted.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         cnt_q <= '0;
      end else if (capture_op) begin
         cnt_q <= '0;
      end else if (((state_q == REQ) || (state_q == WAIT_R)) && (cnt_q != 8'hFF)) begin
         cnt_q <= cnt_q + 8'd1;
      end
   end

   // Load result register; holds until the next successful load.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset)           rdata_q <= '0;
      else if (capture_rdata) rdata_q <= lane_rdata;
   end

endmodule

// File: tb/tb_hippo_lsu_ctrl.sv
// Directed self-checking bench for hippo_lsu_ctrl (TIMEOUT = 4).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_hippo_lsu_ctrl;

   logic        clk;
   logic        rst_n;
   logic        i_valid, i_load, i_store;
   logic [2:0]  i_width;
   logic [31:0] i_addr, i_wdata;
   logic        o_stall, o_rdata_valid, o_trap;
   logic [31:0] o_rdata;
   logic [1:0]  o_trap_cause;
   logic [31:0] last_rdata;
   int          errors = 0;
   int          checks = 0;

   hippo_lsu_ctrl_if #(.XLEN(32)) bus ();

   hippo_lsu_ctrl #(.XLEN(32), .TIMEOUT(4)) dut (
      .i_clk         (clk),
      .i_reset       (rst_n),
      .i_valid       (i_valid),
      .i_load        (i_load),
      .i_store       (i_store),
      .i_width       (i_width),
      .i_addr        (i_addr),
      .i_wdata       (i_wdata),
      .o_stall       (o_stall),
      .o_rdata       (o_rdata),
      .o_rdata_valid (o_rdata_valid),
      .o_trap        (o_trap),
      .o_trap_cause  (o_trap_cause),
      .bus           (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_op(input logic vld, input logic ld, input logic st,
                         input logic [2:0] w, input logic [31:0] a, input logic [31:0] d);
      i_valid = vld;
      i_load  = ld;
      i_store = st;
      i_width = w;
      i_addr  = a;
      i_wdata = d;
   endtask

   task automatic set_bus(input logic gnt, input logic rv, input logic [31:0] rd);
      bus.i_bus_gnt    = gnt;
      bus.i_bus_rvalid = rv;
      bus.i_bus_rdata  = rd;
   endtask

   task automatic idle_op();
      set_op(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
   endtask

   initial begin
      rst_n = 1'b0;
      idle_op();
      set_bus(1'b0, 1'b0, 32'h0);
      last_rdata = 32'h0;

      // ---- reset state ----
      tick(); tick(); settle();
      check("rst_stall", 32'(o_stall), 32'd0);
      check("rst_req",   32'(bus.o_bus_req), 32'd0);
      check("rst_trap",  32'(o_trap), 32'd0);
      check("rst_rvld",  32'(o_rdata_valid), 32'd0);
      check("rst_rdata", o_rdata, 32'h0);
      check("rst_addr",  bus.o_bus_addr, 32'h0);
      check("rst_be",    32'(bus.o_bus_be), 32'd0);
      check("rst_we",    32'(bus.o_bus_we), 32'd0);
      check("rst_wdata", bus.o_bus_wdata, 32'h0);
      tick(); rst_n = 1'b1; settle();
      check("idle_stall", 32'(o_stall), 32'd0);

      // ---- SW 0x100 <- 0xDEADBEEF, grant on 2nd REQ cycle ----
      tick(); set_op(1'b1, 1'b0, 1'b1, 3'd2, 32'h100, 32'hDEADBEEF); settle();
      check("sw_idle_stall", 32'(o_stall), 32'd1);
      check("sw_idle_req",   32'(bus.o_bus_req), 32'd0);
      tick(); settle();
      check("sw_req1_req",   32'(bus.o_bus_req), 32'd1);
      check("sw_req1_stall", 32'(o_stall), 32'd1);
      check("sw_addr",       bus.o_bus_addr, 32'h100);
      check("sw_be",         32'(bus.o_bus_be), 32'hF);
      check("sw_wdata",      bus.o_bus_wdata, 32'hDEADBEEF);
      check("sw_we",         32'(bus.o_bus_we), 32'd1);
      tick(); set_bus(1'b1, 1'b0, 32'h0); settle();
      check("sw_req2_stall", 32'(o_stall), 32'd1);
      check("sw_req2_addr",  bus.o_bus_addr, 32'h100);
      tick(); set_bus(1'b0, 1'b0, 32'h0); settle();
      check("sw_done_stall", 32'(o_stall), 32'd0);
      check("sw_done_trap",  32'(o_trap), 32'd0);
      check("sw_done_rvld",  32'(o_rdata_valid), 32'd0);
      check("sw_done_req",   32'(bus.o_bus_req), 32'd0);
      tick(); idle_op(); settle();
      check("sw_after_stall", 32'(o_stall), 32'd0);

      // ---- LB 0x203, grant+rvalid together ----
      tick(); set_op(1'b1, 1'b1, 1'b0, 3'd0, 32'h203, 32'h0); settle();
      check("lb_idle_stall", 32'(o_stall), 32'd1);
      tick(); set_bus(1'b1, 1'b1, 32'h80123456); settle();
      check("lb_req",   32'(bus.o_bus_req), 32'd1);
      check("lb_addr",  bus.o_bus_addr, 32'h200);
      check("lb_be",    32'(bus.o_bus_be), 32'b1000);
      check("lb_we",    32'(bus.o_bus_we), 32'd0);
      tick(); set_bus(1'b0, 1'b0, 32'h0); settle();
      check("lb_done_stall", 32'(o_stall), 32'd0);
      check("lb_done_rvld",  32'(o_rdata_valid), 32'd1);
      check("lb_rdata",      o_rdata, 32'hFFFFFF80);
      tick(); idle_op(); settle();
      check("lb_rvld_pulse", 32'(o_rdata_valid), 32'd0);
      check("lb_rdata_hold", o_rdata, 32'hFFFFFF80);

      // ---- LBU 0x203, same stimulus ----
      tick(); set_op(1'b1, 1'b1, 1'b0, 3'd4, 32'h203, 32'h0); settle();
      tick(); set_bus(1'b1, 1'b1, 32'h80123456); settle();
      tick(); set_bus(1'b0, 1'b0, 32'h0); settle();
      check("lbu_rvld",  32'(o_rdata_valid), 32'd1);
      check("lbu_rdata", o_rdata, 32'h00000080);
      last_rdata = 32'h00000080;
      tick(); idle_op(); settle();

      // ---- SH 0x12 <- 0x0000ABCD ----
      tick(); set_op(1'b1, 1'b0, 1'b1, 3'd1, 32'h12, 32'h0000ABCD); settle();
      check("sh_idle_stall", 32'(o_stall), 32'd1);
      tick(); set_bus(1'b1, 1'b0, 32'h0); settle();
      check("sh_addr",  bus.o_bus_addr, 32'h10);
      check("sh_be",    32'(bus.o_bus_be), 32'b1100);
      check("sh_wdata", bus.o_bus_wdata, 32'hABCDABCD);
      check("sh_we",    32'(bus.o_bus_we), 32'd1);
      tick(); set_bus(1'b0, 1'b0, 32'h0); settle();
      check("sh_done_stall", 32'(o_stall), 32'd0);
      check("sh_done_trap",  32'(o_trap), 32'd0);
      tick(); idle_op(); settle();

      // ---- LW 0x102 (misaligned word) ----
`ifdef HIPPO_LSU_MISALIGN_TRAP_EN
      tick(); set_op(1'b1, 1'b1, 1'b0, 3'd2, 32'h102, 32'h0); settle();
      check("lwmis_trap",  32'(o_trap), 32'd1);
      check("lwmis_cause", 32'(o_trap_cause), 32'd1);
      check("lwmis_stall", 32'(o_stall), 32'd0);
      check("lwmis_req",   32'(bus.o_bus_req), 32'd0);
      tick(); idle_op(); settle();
      check("lwmis_after_req",  32'(bus.o_bus_req), 32'd0);
      check("lwmis_after_trap", 32'(o_trap), 32'd0);
      // SW 0x101 -> store misaligned
      tick(); set_op(1'b1, 1'b0, 1'b1, 3'd2, 32'h101, 32'h5A5A5A5A); settle();
      check("swmis_trap",  32'(o_trap), 32'd1);
      check("swmis_cause", 32'(o_trap_cause), 32'd2);
      check("swmis_req",   32'(bus.o_bus_req), 32'd0);
      tick(); idle_op(); settle();
      check("swmis_after_req", 32'(bus.o_bus_req), 32'd0);
`else
      tick(); set_op(1'b1, 1'b1, 1'b0, 3'd2, 32'h102, 32'h0); settle();
      check("lw102_trap",  32'(o_trap), 32'd0);
      check("lw102_stall", 32'(o_stall), 32'd1);
      tick(); set_bus(1'b1, 1'b1, 32'h11223344); settle();
      check("lw102_addr",  bus.o_bus_addr, 32'h100);
      check("lw102_be",    32'(bus.o_bus_be), 32'hF);
      tick(); set_bus(1'b0, 1'b0, 32'h0); settle();
      check("lw102_rvld",  32'(o_rdata_valid), 32'd1);
      check("lw102_rdata", o_rdata, 32'h11223344);
      last_rdata = 32'h11223344;
      tick(); idle_op(); settle();
`endif

      // ---- LW 0x40 with grant but no rvalid: bus timeout ----
      tick(); set_op(1'b1, 1'b1, 1'b0, 3'd2, 32'h40, 32'h0); settle();
      tick(); set_bus(1'b1, 1'b0, 32'h0); settle();
      check("to_req", 32'(bus.o_bus_req), 32'd1);
      tick(); set_bus(1'b0, 1'b0, 32'h0); settle();
      check("to_w1_req",   32'(bus.o_bus_req), 32'd0);
      check("to_w1_stall", 32'(o_stall), 32'd1);
      tick(); settle();
      check("to_w2_stall", 32'(o_stall), 32'd1);
      tick(); settle();
      check("to_w3_stall", 32'(o_stall), 32'd1);
      check("to_w3_trap",  32'(o_trap), 32'd0);
      tick(); settle();
      check("to_done_stall", 32'(o_stall), 32'd0);
      check("to_done_trap",  32'(o_trap), 32'd1);
      check("to_done_cause", 32'(o_trap_cause), 32'd3);
      check("to_done_rvld",  32'(o_rdata_valid), 32'd0);
      tick(); idle_op(); set_bus(1'b0, 1'b1, 32'hCAFEF00D); settle();
      check("to_late_trap",  32'(o_trap), 32'd0);
      check("to_late_rvld",  32'(o_rdata_valid), 32'd0);
      tick(); set_bus(1'b0, 1'b0, 32'h0); settle();
      check("to_late_rdata", o_rdata, last_rdata);
      check("to_late_rvld2", 32'(o_rdata_valid), 32'd0);

      // ---- reset asserted while in WAIT_R ----
      tick(); set_op(1'b1, 1'b1, 1'b0, 3'd2, 32'h80, 32'h0); settle();
      tick(); set_bus(1'b1, 1'b0, 32'h0); settle();
      check("rw_req_addr", bus.o_bus_addr, 32'h80);
      tick(); set_bus(1'b0, 1'b0, 32'h0); settle();
      check("rw_wait_stall", 32'(o_stall), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rw_rst_stall", 32'(o_stall), 32'd0);
      check("rw_rst_req",   32'(bus.o_bus_req), 32'd0);
      check("rw_rst_addr",  bus.o_bus_addr, 32'h0);
      check("rw_rst_trap",  32'(o_trap), 32'd0);
      check("rw_rst_rvld",  32'(o_rdata_valid), 32'd0);
      check("rw_rst_rdata", o_rdata, 32'h0);
      tick(); idle_op(); rst_n = 1'b1; settle();
      check("rw_rel_stall", 32'(o_stall), 32'd0);
      // SW 0x44 <- 0x12345678 after release
      tick(); set_op(1'b1, 1'b0, 1'b1, 3'd2, 32'h44, 32'h12345678); settle();
      check("rsw_idle_stall", 32'(o_stall), 32'd1);
      tick(); set_bus(1'b1, 1'b0, 32'h0); settle();
      check("rsw_req",   32'(bus.o_bus_req), 32'd1);
      check("rsw_addr",  bus.o_bus_addr, 32'h44);
      check("rsw_be",    32'(bus.o_bus_be), 32'hF);
      check("rsw_wdata", bus.o_bus_wdata, 32'h12345678);
      tick(); set_bus(1'b0, 1'b0, 32'h0); settle();
      check("rsw_done_stall", 32'(o_stall), 32'd0);
      check("rsw_done_trap",  32'(o_trap), 32'd0);
      tick(); idle_op(); settle();
      check("rsw_after_req", 32'(bus.o_bus_req), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
